ram_initiator: RTL and testbench

RAM_INITIATOR -- requirements
Module: ram_initiator

---
 rtl/ram_initiator_if.sv | 24 ++
 rtl/ram_initiator.sv | 133 +++++++++++++
 tb/tb_ram_initiator.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_initiator_if.sv
// Single-port RAM handshake: the client issues en/we/be/addr/data_w.
// The memory answers with data_r one cycle after completion, and may stall with delay.
interface Ram_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) ();
  logic                    en;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   data_w;
  logic [DATA_WIDTH-1:0]   data_r;
  logic                    delay;

  modport client (
    output en, we, be, addr, data_w,
    input  data_r, delay
  );

  modport memory (
    input  en, we, be, addr, data_w,
    output data_r, delay
  );
endinterface

// File: rtl/ram_initiator.sv
// Command-to-RAM initiator: one registered access at a time, retried while delayed,
// with read data returned in order through a credit-protected response FIFO.
module ram_initiator #(
  parameter  int ADDR_WIDTH = 10,
  parameter  int DATA_WIDTH = 32,
  parameter  int RESP_DEPTH = 2,
  localparam int BYTE_COUNT = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [BYTE_COUNT-1:0] cmd_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy,
  output logic [15:0]           delay_cnt,
  Ram_if.client                 intf
);

  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 3);

  logic                  r_issue_valid;
  logic                  r_issue_we;
  logic [ADDR_WIDTH-1:0] r_issue_addr;
  logic [DATA_WIDTH-1:0] r_issue_data;
  logic [BYTE_COUNT-1:0] r_issue_be;
  logic                  r_capture_pending;
  logic [DATA_WIDTH-1:0] r_fifo [RESP_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic [15:0]           r_delay_cnt;

  logic                  w_issue_is_read;
  logic                  w_issue_done;
  logic                  w_cmd_fire;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_credit_ok;
  logic [CNT_W-1:0]      w_credit_sum;

  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reads in flight (issued, awaiting capture, or buffered) each hold one FIFO slot.
  assign w_issue_is_read = r_issue_valid && !r_issue_we;
  assign w_issue_done    = r_issue_valid && !intf.delay;
  assign w_credit_sum    = r_count + CNT_W'(w_issue_is_read) + CNT_W'(r_capture_pending);
  assign w_credit_ok     = w_credit_sum < CNT_W'(RESP_DEPTH);
  assign cmd_ready       = (!r_issue_valid || !intf.delay) && w_credit_ok;
  assign w_cmd_fire      = cmd_valid && cmd_ready;
  assign w_push          = r_capture_pending;
  assign w_pop           = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_issue_valid <= 1'b0;
      r_issue_we    <= 1'b0;
      r_issue_addr  <= '0;
      r_issue_data  <= '0;
      r_issue_be    <= '0;
    end else if (w_cmd_fire) begin
      r_issue_valid <= 1'b1;
      r_issue_we    <= cmd_we;
      r_issue_addr  <= cmd_addr;
      r_issue_data  <= cmd_data;
      r_issue_be    <= cmd_be;
    end else if (w_issue_done) begin
      r_issue_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_capture_pending <= 1'b0;
    end else begin
      r_capture_pending <= w_issue_done && !r_issue_we;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= intf.data_r;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= f_next(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= f_next(r_rptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_delay_cnt <= '0;
    end else if (intf.en && intf.delay && (r_delay_cnt != '1)) begin
      r_delay_cnt <= r_delay_cnt + 1'b1;
    end
  end

  assign intf.en     = r_issue_valid;
  assign intf.we     = r_issue_we;
  assign intf.be     = r_issue_be;
  assign intf.addr   = r_issue_addr;
  assign intf.data_w = r_issue_data;

  assign rsp_valid = (r_count != '0);
  assign rsp_data  = r_fifo[r_rptr];
  assign busy      = r_issue_valid || r_capture_pending || (r_count != '0);
  assign delay_cnt = r_delay_cnt;

endmodule

// File: tb/tb_ram_initiator.sv
// Bench for ram_initiator: DUT A uses the default response depth, DUT B a depth of 4 for streaming.
module tb_ram_initiator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        a_cmd_valid, a_cmd_we, a_cmd_ready, a_rsp_valid, a_rsp_ready, a_busy;
  logic [9:0]  a_cmd_addr;
  logic [31:0] a_cmd_data, a_rsp_data;
  logic [3:0]  a_cmd_be;
  logic [15:0] a_delay_cnt;

  logic        b_cmd_valid, b_cmd_we, b_cmd_ready, b_rsp_valid, b_rsp_ready, b_busy;
  logic [9:0]  b_cmd_addr;
  logic [31:0] b_cmd_data, b_rsp_data;
  logic [3:0]  b_cmd_be;
  logic [15:0] b_delay_cnt;

  Ram_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) a_if ();
  Ram_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) b_if ();

  ram_initiator #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .RESP_DEPTH(2)) dut_a (
    .clk(clk), .reset(reset),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_we(a_cmd_we),
    .cmd_addr(a_cmd_addr), .cmd_data(a_cmd_data), .cmd_be(a_cmd_be),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
    .busy(a_busy), .delay_cnt(a_delay_cnt), .intf(a_if)
  );

  ram_initiator #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .RESP_DEPTH(4)) dut_b (
    .clk(clk), .reset(reset),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_we(b_cmd_we),
    .cmd_addr(b_cmd_addr), .cmd_data(b_cmd_data), .cmd_be(b_cmd_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
    .busy(b_busy), .delay_cnt(b_delay_cnt), .intf(b_if)
  );

  // Memory models: synchronous, data_r valid the cycle after a completed read.
  logic [31:0] a_mem [1024];
  logic [31:0] b_mem [1024];
  int unsigned a_delay_req = 0;
  int unsigned a_delay_used = 0;

  assign a_if.delay = a_if.en && (a_delay_used < a_delay_req);
  assign b_if.delay = 1'b0;

  always @(posedge clk) begin
    if (a_if.en && a_if.delay) a_delay_used <= a_delay_used + 1;
    if (a_if.en && !a_if.delay) begin
      if (a_if.we) begin
        for (int k = 0; k < 4; k++)
          if (a_if.be[k]) a_mem[a_if.addr][8*k +: 8] <= a_if.data_w[8*k +: 8];
      end else begin
        a_if.data_r <= a_mem[a_if.addr];
      end
    end
  end

  always @(posedge clk) begin
    if (b_if.en && !b_if.delay) begin
      if (b_if.we) begin
        for (int k = 0; k < 4; k++)
          if (b_if.be[k]) b_mem[b_if.addr][8*k +: 8] <= b_if.data_w[8*k +: 8];
      end else begin
        b_if.data_r <= b_mem[b_if.addr];
      end
    end
  end

  logic [31:0] a_q [$];
  logic [31:0] b_q [$];
  int tests = 0;
  int fails = 0;
  int a_rsp_n = 0;
  int b_rsp_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: compares the FIFO head every cycle it is presented, pops on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (a_rsp_valid) begin
          if (a_q.size() == 0) chk("a_unexpected_rsp", a_rsp_data, 32'hx);
          else begin
            chk("a_rsp_data", a_rsp_data, a_q[0]);
            if (a_rsp_ready) begin void'(a_q.pop_front()); a_rsp_n++; end
          end
        end
        if (b_rsp_valid) begin
          if (b_q.size() == 0) chk("b_unexpected_rsp", b_rsp_data, 32'hx);
          else begin
            chk("b_rsp_data", b_rsp_data, b_q[0]);
            if (b_rsp_ready) begin void'(b_q.pop_front()); b_rsp_n++; end
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit sel, input logic we, input logic [9:0] addr,
                      input logic [31:0] data, input logic [3:0] be,
                      input logic [31:0] exp, output int waited);
    int n;
    n = 0;
    if (!sel) begin
      a_cmd_valid = 1'b1; a_cmd_we = we; a_cmd_addr = addr; a_cmd_data = data; a_cmd_be = be;
    end else begin
      b_cmd_valid = 1'b1; b_cmd_we = we; b_cmd_addr = addr; b_cmd_data = data; b_cmd_be = be;
    end
    #1;
    while (!(sel ? b_cmd_ready : a_cmd_ready) && n < 50) begin
      cyc(); #1; n++;
    end
    if (n == 50) chk(sel ? "b_accept_timeout" : "a_accept_timeout", 32'd0, 32'd1);
    else begin
      if (!we) begin
        if (!sel) a_q.push_back(exp);
        else      b_q.push_back(exp);
      end
      cyc();
    end
    a_cmd_valid = 1'b0;
    b_cmd_valid = 1'b0;
    waited = n;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((a_busy || b_busy || a_q.size() != 0 || b_q.size() != 0) && n < 200) begin
      cyc(); n++;
    end
    if (n == 200) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] bp_val [4] = '{32'hB0B0_0000, 32'hB0B0_1111, 32'hB0B0_2222, 32'hB0B0_3333};

  initial begin
    int w, acc, n_en, n_lim, rsp0;
    reset = 1'b0;
    a_cmd_valid = 0; a_cmd_we = 0; a_cmd_addr = '0; a_cmd_data = '0; a_cmd_be = '0; a_rsp_ready = 1;
    b_cmd_valid = 0; b_cmd_we = 0; b_cmd_addr = '0; b_cmd_data = '0; b_cmd_be = '0; b_rsp_ready = 1;
    repeat (3) cyc();
    reset = 1'b1;
    #1;
    chk("rst_en", a_if.en, 0);
    chk("rst_rsp_valid", a_rsp_valid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_delay_cnt", a_delay_cnt, 0);
    chk("rst_cmd_ready", a_cmd_ready, 1);

    send(0, 1, 10'h005, 32'hDEADBEEF, 4'hF, 0, w);
    send(0, 1, 10'h007, 32'h12345678, 4'hF, 0, w);
    send(0, 1, 10'h010, 32'hAABBCCDD, 4'hF, 0, w);
    for (int i = 0; i < 4; i++) send(0, 1, 10'h020 + 10'(i), bp_val[i], 4'hF, 0, w);
    wait_idle();

    // Plain read latency: en at T+1, rsp_valid first at T+3.
    send(0, 0, 10'h005, 0, 0, 32'hDEADBEEF, w);
    chk("rd_en_t1", a_if.en, 1);
    chk("rd_addr_t1", a_if.addr, 10'h005);
    chk("rd_we_t1", a_if.we, 0);
    cyc();
    chk("rd_valid_t2", a_rsp_valid, 0);
    cyc();
    chk("rd_valid_t3", a_rsp_valid, 1);
    wait_idle();

    send(0, 1, 10'h010, 32'h11223344, 4'b0101, 0, w);
    chk("wr_we", a_if.we, 1);
    chk("wr_be", a_if.be, 4'b0101);
    send(0, 0, 10'h010, 0, 0, 32'hAA22CC44, w);
    wait_idle();

    // Three delayed cycles on one read.
    rsp0 = a_rsp_n;
    a_delay_req = a_delay_used + 3;
    send(0, 0, 10'h007, 0, 0, 32'h12345678, w);
    n_en = 0; n_lim = 0;
    while (a_if.en && n_lim < 20) begin
      n_en++;
      chk("dly_addr", a_if.addr, 10'h007);
      if (a_if.delay) chk("dly_cmd_ready", a_cmd_ready, 0);
      cyc(); n_lim++;
    end
    chk("dly_en_cycles", n_en, 4);
    chk("dly_delay_cnt", a_delay_cnt, 3);
    wait_idle();
    chk("dly_rsp_count", a_rsp_n - rsp0, 1);

    // Backpressure: only two reads fit with rsp_ready low.
    a_rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      a_cmd_valid = (acc < 4); a_cmd_we = 0; a_cmd_addr = 10'h020 + 10'(acc);
      #1;
      if (a_cmd_valid && a_cmd_ready) begin a_q.push_back(bp_val[acc]); acc++; end
      cyc();
    end
    a_cmd_valid = 1'b1; a_cmd_addr = 10'h020 + 10'(acc);
    #1;
    chk("bp_accepted", acc, 2);
    chk("bp_cmd_ready", a_cmd_ready, 0);
    a_rsp_ready = 1'b1;
    n_lim = 0;
    while (acc < 4 && n_lim < 50) begin
      a_cmd_valid = 1'b1; a_cmd_addr = 10'h020 + 10'(acc);
      #1;
      if (a_cmd_ready) begin a_q.push_back(bp_val[acc]); acc++; end
      cyc(); n_lim++;
    end
    a_cmd_valid = 1'b0;
    chk("bp_all_accepted", acc, 4);
    wait_idle();

    // Streaming on the deeper FIFO: one access per cycle.
    for (int i = 0; i < 8; i++) send(1, 1, 10'(i), 32'hC0DE_0000 + 32'(i * 'h111), 4'hF, 0, w);
    repeat (3) cyc();
    rsp0 = b_rsp_n;
    for (int i = 0; i < 8; i++) begin
      send(1, 0, 10'(i), 0, 0, 32'hC0DE_0000 + 32'(i * 'h111), w);
      chk("st_wait", w, 0);
      chk("st_en", b_if.en, 1);
      chk("st_addr", b_if.addr, 10'(i));
    end
    cyc();
    chk("st_en_done", b_if.en, 0);
    wait_idle();
    chk("st_rsp_count", b_rsp_n - rsp0, 8);

    // Reset during a delayed read abandons it.
    a_delay_req = a_delay_used + 5;
    send(0, 0, 10'h005, 0, 0, 32'hDEADBEEF, w);
    cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    a_q.delete();
    a_delay_req = a_delay_used;
    #1;
    chk("mr_en", a_if.en, 0);
    chk("mr_rsp_valid", a_rsp_valid, 0);
    chk("mr_delay_cnt", a_delay_cnt, 0);
    chk("mr_busy", a_busy, 0);
    chk("mr_cmd_ready", a_cmd_ready, 1);
    rsp0 = a_rsp_n;
    repeat (10) cyc();
    chk("mr_no_rsp", a_rsp_n - rsp0, 0);
    chk("mr_rsp_valid_late", a_rsp_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
